// File: rtl/tsc_multicycle_core.sv
// tsc_multicycle_core: multi-cycle TSC CPU (FETCH/DECODE/EXEC/WB/HALT).
// Instructions arrive over a req/ack port; four registers of WORD_SIZE bits.
// Optional feature macro NUM_INST_EN adds the num_inst retired-instruction
// counter port. It is absent when the macro is undefined.
module tsc_multicycle_core #(
   parameter int WORD_SIZE = 16,
   parameter int PC_WIDTH  = 8,
   parameter int RESET_PC  = 0
) (
   input  logic                 clk,
   input  logic                 reset_cpu,
   input  logic                 cpu_enable,
   input  logic                 wwd_enable,
   input  logic [1:0]           register_selection,
   output logic                 imem_req,
   output logic [PC_WIDTH-1:0]  imem_addr,
   input  logic                 imem_ack,
   input  logic [15:0]          imem_data,
   output logic [WORD_SIZE-1:0] output_port,
   output logic [7:0]           PC_below8bit,
`ifdef NUM_INST_EN
   output logic [WORD_SIZE-1:0] num_inst,
`endif
   output logic                 halted
);

   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT} state_t;

   localparam logic [3:0] OP_BNE = 4'd0, OP_BEQ = 4'd1, OP_ADI = 4'd4, OP_ORI = 4'd5,
                          OP_LHI = 4'd6, OP_JMP = 4'd9, OP_R   = 4'd15;

   state_t               state, state_nx;
   logic [PC_WIDTH-1:0]  pc, npc;
   logic [15:0]          ir;
   logic [WORD_SIZE-1:0] regs [4];
   logic [WORD_SIZE-1:0] a, b, result, wwd_reg;
   logic [1:0]           wr_addr;
   logic                 wr_en, is_wwd, is_hlt;

   // decoded fields
   logic [3:0] op;
   logic [1:0] rs, rt, rd;
   logic [5:0] func;
   logic [7:0] imm;
   assign op   = ir[15:12];
   assign rs   = ir[11:10];
   assign rt   = ir[9:8];
   assign rd   = ir[7:6];
   assign func = ir[5:0];
   assign imm  = ir[7:0];

   // execute-stage combinational results
   logic [WORD_SIZE-1:0] alu_res;
   logic [PC_WIDTH-1:0]  alu_npc, pc_inc, br_off;
   logic [1:0]           alu_waddr;
   logic                 alu_we, alu_wwd, alu_hlt;
   logic [15:0]          imm_s16;
   logic [WORD_SIZE-1:0] imm_sx, imm_zx, imm_hi;

   assign imm_s16 = 16'($signed(imm));
   assign br_off  = imm_s16[PC_WIDTH-1:0];
   assign pc_inc  = pc + PC_WIDTH'(1);
   assign imm_sx  = WORD_SIZE'($signed(imm));
   assign imm_zx  = WORD_SIZE'(imm);
   assign imm_hi  = WORD_SIZE'({imm, 8'h00});

   assign imem_addr = pc;
   assign halted    = (state == S_HALT);

   generate
      if (PC_WIDTH >= 8) begin : g_pc_lo
         assign PC_below8bit = pc[7:0];
      end else begin : g_pc_zx
         assign PC_below8bit = {{(8 - PC_WIDTH){1'b0}}, pc};
      end
   endgenerate

   // state register
   always_ff @(posedge clk) begin
      if (reset_cpu) state <= S_FETCH;
      else           state <= state_nx;
   end

   // next-state and fetch request; no request while reset is held so a
   // fetch is never granted in a cycle whose result is discarded
   always_comb begin
      state_nx = state;
      imem_req = 1'b0;
      case (state)
         S_FETCH: begin
            imem_req = cpu_enable && !reset_cpu;
            if (imem_req && imem_ack) state_nx = S_DECODE;
         end
         S_DECODE: state_nx = S_EXEC;
         S_EXEC:   state_nx = S_WB;
         S_WB:     state_nx = is_hlt ? S_HALT : S_FETCH;
         S_HALT:   state_nx = S_HALT;
         default:  state_nx = S_FETCH;
      endcase
   end

   // ALU, branch and jump resolution from latched operands
   always_comb begin
      alu_res   = '0;
      alu_we    = 1'b0;
      alu_waddr = rt;
      alu_npc   = pc_inc;
      alu_wwd   = 1'b0;
      alu_hlt   = 1'b0;
      case (op)
         OP_BNE: if (a != b) alu_npc = pc_inc + br_off;
         OP_BEQ: if (a == b) alu_npc = pc_inc + br_off;
         OP_ADI: begin alu_res = a + imm_sx; alu_we = 1'b1; end
         OP_ORI: begin alu_res = a | imm_zx; alu_we = 1'b1; end
         OP_LHI: begin alu_res = imm_hi;     alu_we = 1'b1; end
         OP_JMP: alu_npc = ir[PC_WIDTH-1:0];
         OP_R: begin
            alu_waddr = rd;
            alu_we    = 1'b1;
            case (func)
               6'd0:  alu_res = a + b;
               6'd1:  alu_res = a - b;
               6'd2:  alu_res = a & b;
               6'd3:  alu_res = a | b;
               6'd4:  alu_res = ~a;
               6'd5:  alu_res = ~a + WORD_SIZE'(1);
               6'd6:  alu_res = {a[WORD_SIZE-2:0], 1'b0};
               6'd7:  alu_res = {a[WORD_SIZE-1], a[WORD_SIZE-1:1]};
               6'd28: begin alu_res = a; alu_we = 1'b0; alu_wwd = 1'b1; end
               6'd29: begin alu_we = 1'b0; alu_hlt = 1'b1; alu_npc = pc; end
               default: alu_we = 1'b0;
            endcase
         end
         default: ;
      endcase
   end

   // datapath: IR capture, operand latch, execute results, write-back
   always_ff @(posedge clk) begin
      if (reset_cpu) begin
         pc      <= PC_WIDTH'(RESET_PC);
         ir      <= '0;
         a       <= '0;
         b       <= '0;
         result  <= '0;
         npc     <= '0;
         wr_addr <= '0;
         wr_en   <= 1'b0;
         is_wwd  <= 1'b0;
         is_hlt  <= 1'b0;
         wwd_reg <= '0;
         for (int i = 0; i < 4; i++) regs[i] <= '0;
      end else begin
         case (state)
            S_FETCH: if (imem_req && imem_ack) ir <= imem_data;
            S_DECODE: begin
               a <= regs[rs];
               b <= regs[rt];
            end
            S_EXEC: begin
               result  <= alu_res;
               npc     <= alu_npc;
               wr_addr <= alu_waddr;
               wr_en   <= alu_we;
               is_wwd  <= alu_wwd;
               is_hlt  <= alu_hlt;
            end
            S_WB: begin
               if (wr_en)  regs[wr_addr] <= result;
               if (is_wwd) wwd_reg <= result;
               pc <= npc;
            end
            default: ;
         endcase
      end
   end

`ifdef NUM_INST_EN
   // retired-instruction counter, HLT excluded
   always_ff @(posedge clk) begin
      if (reset_cpu)                  num_inst <= '0;
      else if (state == S_WB && !is_hlt) num_inst <= num_inst + WORD_SIZE'(1);
   end
`endif

   // registered display mux
   always_ff @(posedge clk) begin
      if (reset_cpu) output_port <= '0;
      else           output_port <= wwd_enable ? wwd_reg : regs[register_selection];
   end

endmodule
